// File: rtl/tx_huge_pages_writer_pkg.sv
// tx_huge_pages_writer_pkg: TLP constants, FSM states and DW byte swap shared by the TX writer and RX decoder
package tx_huge_pages_writer_pkg;
    localparam logic [6:0] FMT_TYPE_MWR64 = 7'b11_00000;
    typedef enum logic [2:0] {IDLE, HDR1, HDR2, DATA, FREE} state_t;
    // Reverse the byte order inside each 32-bit DW of a 64-bit word
    function automatic logic [63:0] dw_swap(input logic [63:0] d);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[i*8 +: 8] = d[(i ^ 3)*8 +: 8];
        return r;
    endfunction
endpackage

// File: rtl/tx_huge_pages_writer_swap.sv
// dw_byte_swap: byte swap within each DW of a 64-bit data word
module dw_byte_swap
    import tx_huge_pages_writer_pkg::*;
(
    input  logic [63:0] din,
    output logic [63:0] dout
);
    assign dout = dw_swap(din);
endmodule

// File: rtl/tx_huge_pages_writer.sv
// tx_huge_pages_writer: streams source-FIFO words as MWr64 TLPs into two ping-pong host huge pages
module tx_huge_pages_writer
    import tx_huge_pages_writer_pkg::*;
#(
    parameter int PAYLOAD_QW = 16,
    parameter int PAGE_BYTES = 2097152
) (
    input  logic        trn_clk,
    input  logic        reset_n,
    input  logic [15:0] cfg_completer_id,
    input  logic [63:0] huge_page_addr_1,
    input  logic [63:0] huge_page_addr_2,
    input  logic        huge_page_status_1,
    input  logic        huge_page_status_2,
    output logic        huge_page_free_1,
    output logic        huge_page_free_2,
    input  logic [63:0] fifo_dout,
    input  logic [9:0]  fifo_count,
    output logic        fifo_rd_en,
    output logic [63:0] trn_td,
    output logic [7:0]  trn_trem_n,
    output logic        trn_tsof_n,
    output logic        trn_teof_n,
    output logic        trn_tsrc_rdy_n,
    output logic        trn_tsrc_dsc_n,
    input  logic        trn_tdst_rdy_n,
    input  logic [5:0]  trn_tbuf_av
);
    localparam logic [21:0] STEP = 22'(PAYLOAD_QW * 8);
    localparam logic [21:0] PAGE_END = 22'(PAGE_BYTES);
    localparam logic [9:0] LAST = 10'(PAYLOAD_QW - 1);
    state_t state;
    logic cur_page, idle_hold, armed, accept, unused_tbuf;
    logic [21:0] offset, next_offset;
    logic [9:0] beat;
    logic [63:0] td_reg, data_sw, addr;
    assign armed = cur_page ? huge_page_status_2 : huge_page_status_1;
    assign addr = (cur_page ? huge_page_addr_2 : huge_page_addr_1) + {42'd0, offset};
    assign next_offset = offset + STEP;
    assign accept = !trn_tsrc_rdy_n && !trn_tdst_rdy_n;
    // Payload comes straight from the FWFT head so a stalled beat holds without extra buffering
    assign trn_td = state == DATA ? data_sw : td_reg;
    assign fifo_rd_en = state == DATA && !trn_tdst_rdy_n;
    assign trn_trem_n = 8'h00;
    assign trn_tsrc_dsc_n = 1'b1;
    assign unused_tbuf = ^{trn_tbuf_av[5:3], trn_tbuf_av[1:0]};
    dw_byte_swap u_swap (.din(fifo_dout), .dout(data_sw));
    always_ff @(posedge trn_clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cur_page <= 1'b0;
            idle_hold <= 1'b0;
            offset <= '0;
            beat <= '0;
            td_reg <= '0;
            trn_tsof_n <= 1'b1;
            trn_teof_n <= 1'b1;
            trn_tsrc_rdy_n <= 1'b1;
            huge_page_free_1 <= 1'b0;
            huge_page_free_2 <= 1'b0;
        end else begin
            huge_page_free_1 <= 1'b0;
            huge_page_free_2 <= 1'b0;
            case (state)
                IDLE: begin
                    // One extra idle cycle lets the host's status update reach us before re-arming
                    if (idle_hold) begin
                        idle_hold <= 1'b0;
                    end else if (armed && fifo_count >= 10'(PAYLOAD_QW) && trn_tbuf_av[2]) begin
                        state <= HDR1;
                        td_reg <= {1'b0, FMT_TYPE_MWR64, 14'h0, 10'(PAYLOAD_QW * 2), cfg_completer_id, 8'h00, 4'hF, 4'hF};
                        trn_tsof_n <= 1'b0;
                        trn_tsrc_rdy_n <= 1'b0;
                    end
                end
                HDR1: if (accept) begin
                    state <= HDR2;
                    td_reg <= addr & ~64'd3;
                    trn_tsof_n <= 1'b1;
                end
                HDR2: if (accept) begin
                    state <= DATA;
                    beat <= '0;
                    td_reg <= '0;
                    trn_teof_n <= LAST != 10'd0;
                end
                DATA: if (accept) begin
                    if (beat == LAST) begin
                        trn_tsrc_rdy_n <= 1'b1;
                        trn_teof_n <= 1'b1;
                        idle_hold <= 1'b1;
                        if (next_offset == PAGE_END) begin
                            state <= FREE;
                            offset <= '0;
                            cur_page <= !cur_page;
                            huge_page_free_1 <= !cur_page;
                            huge_page_free_2 <= cur_page;
                        end else begin
                            state <= IDLE;
                            offset <= next_offset;
                        end
                    end else begin
                        beat <= beat + 10'd1;
                        trn_teof_n <= beat + 10'd1 != LAST;
                    end
                end
                FREE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tx_huge_pages_writer.sv
// tb_tx_huge_pages_writer: scoreboard bench; stimulus queues expected TLP beats, a negedge monitor checks them
module tb_tx_huge_pages_writer;
    typedef struct {
        logic [63:0] td;
        logic        sof_n;
        logic        eof_n;
        logic        is_data;
        logic        is_free;
        logic [1:0]  fv;
    } exp_t;
    logic        trn_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] cfg_completer_id = 16'hBEEF;
    logic [63:0] huge_page_addr_1 = 64'h0000_0001_FFFF_FF80;
    logic [63:0] huge_page_addr_2 = 64'h0000_0000_4000_0000;
    logic        huge_page_status_1 = 1'b0;
    logic        huge_page_status_2 = 1'b0;
    logic        huge_page_free_1, huge_page_free_2;
    logic [63:0] fifo_dout = '0;
    logic [9:0]  fifo_count = '0;
    logic        fifo_rd_en;
    logic [63:0] trn_td;
    logic [7:0]  trn_trem_n;
    logic        trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, trn_tsrc_dsc_n;
    logic        trn_tdst_rdy_n = 1'b0;
    logic [5:0]  trn_tbuf_av = 6'h04;
    exp_t        exp_q[$];
    exp_t        h;
    logic [63:0] fifo_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          rd_cnt = 0;
    int          rd_start;
    logic        stall = 1'b0;

    always #5 trn_clk = ~trn_clk;

    tx_huge_pages_writer #(.PAYLOAD_QW(16), .PAGE_BYTES(256)) dut (
        .trn_clk(trn_clk), .reset_n(reset_n), .cfg_completer_id(cfg_completer_id),
        .huge_page_addr_1(huge_page_addr_1), .huge_page_addr_2(huge_page_addr_2),
        .huge_page_status_1(huge_page_status_1), .huge_page_status_2(huge_page_status_2),
        .huge_page_free_1(huge_page_free_1), .huge_page_free_2(huge_page_free_2),
        .fifo_dout(fifo_dout), .fifo_count(fifo_count), .fifo_rd_en(fifo_rd_en),
        .trn_td(trn_td), .trn_trem_n(trn_trem_n), .trn_tsof_n(trn_tsof_n), .trn_teof_n(trn_teof_n),
        .trn_tsrc_rdy_n(trn_tsrc_rdy_n), .trn_tsrc_dsc_n(trn_tsrc_dsc_n),
        .trn_tdst_rdy_n(trn_tdst_rdy_n), .trn_tbuf_av(trn_tbuf_av)
    );

    function automatic logic [63:0] swap_dw(input logic [63:0] d);
        return {d[39:32], d[47:40], d[55:48], d[63:56], d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    // FWFT source FIFO model
    always @(posedge trn_clk or negedge reset_n) begin
        if (!reset_n) fifo_q.delete();
        else if (fifo_rd_en && fifo_q.size() != 0) void'(fifo_q.pop_front());
        fifo_dout = fifo_q.size() != 0 ? fifo_q[0] : 64'd0;
    end

    always @(negedge trn_clk) begin
        if (reset_n) begin
            if (fifo_rd_en) rd_cnt++;
            chk("trem_dsc", {trn_trem_n, trn_tsrc_dsc_n}, 9'h001);
            if (!trn_tsrc_rdy_n) begin
                if (exp_q.size() == 0 || exp_q[0].is_free) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_beat: got td=%h, want no beat", trn_td);
                end else begin
                    h = exp_q[0];
                    chk(trn_tdst_rdy_n ? "held_td" : "beat_td", trn_td, h.td);
                    chk(trn_tdst_rdy_n ? "held_sof_eof" : "beat_sof_eof", {trn_tsof_n, trn_teof_n}, {h.sof_n, h.eof_n});
                    chk("rd_en", fifo_rd_en, h.is_data && !trn_tdst_rdy_n);
                    if (!trn_tdst_rdy_n) void'(exp_q.pop_front());
                end
            end else if (fifo_rd_en) begin
                chk("rd_en_idle", fifo_rd_en, 1'b0);
            end
            if (huge_page_free_1 || huge_page_free_2) begin
                if (exp_q.size() == 0 || !exp_q[0].is_free) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_free: got %b, want none", {huge_page_free_2, huge_page_free_1});
                end else begin
                    chk("free_pulse", {huge_page_free_2, huge_page_free_1}, exp_q[0].fv);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic push_tlp(input logic [63:0] addr, input int n_exp);
        exp_t e;
        logic [63:0] w;
        e = '{td: 64'h6000_0020_BEEF_00FF, sof_n: 1'b0, eof_n: 1'b1, is_data: 1'b0, is_free: 1'b0, fv: 2'b00};
        exp_q.push_back(e);
        e.td = addr;
        e.sof_n = 1'b1;
        exp_q.push_back(e);
        for (int i = 0; i < 16; i++) begin
            w = 64'h0011_2233_4455_6677 + 64'h0101_0101_0101_0101 * 64'(i);
            fifo_q.push_back(w);
            if (i < n_exp) begin
                e.td = i == 0 ? 64'h3322_1100_7766_5544 : swap_dw(w);
                e.eof_n = i != 15;
                e.is_data = 1'b1;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic push_free(input logic [1:0] fv);
        exp_t e;
        e = '{td: 64'd0, sof_n: 1'b1, eof_n: 1'b1, is_data: 1'b0, is_free: 1'b1, fv: fv};
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge trn_clk);
        #1;
        if (stall) trn_tdst_rdy_n = ~trn_tdst_rdy_n;
    endtask

    task automatic wait_sof(input string name, input int lim);
        int n = 0;
        while (trn_tsof_n !== 1'b0 && n < lim) begin
            step();
            n++;
        end
        chk(name, 64'(trn_tsof_n), 64'd0);
        fifo_count = 10'd0;
    endtask

    task automatic wait_drain(input string name, input int lim);
        int n = 0;
        while (exp_q.size() != 0 && n < lim) begin
            step();
            n++;
        end
        chk(name, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_td"}, trn_td, 64'd0);
        chk({name, "_ctl"}, {trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n, fifo_rd_en, huge_page_free_1, huge_page_free_2}, 6'b111000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish before 200000");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge trn_clk);
        chk_reset_outputs("reset");
        step();
        reset_n = 1'b1;
        // Page 1 not armed: plenty of data must not start a TLP
        push_tlp(64'h0000_0001_FFFF_FF80, 16);
        fifo_count = 10'd100;
        repeat (10) step();
        chk("unarmed_idle", 64'(trn_tsrc_rdy_n), 64'd1);
        huge_page_status_1 = 1'b1;
        wait_sof("arm_start", 2);
        wait_drain("tlp1_drain", 100);
        // Second page-1 TLP under back-pressure; address carries across bit 31 and fills the page
        huge_page_status_2 = 1'b1;
        rd_start = rd_cnt;
        push_tlp(64'h0000_0002_0000_0000, 16);
        push_free(2'b01);
        fifo_count = 10'd16;
        stall = 1'b1;
        wait_sof("stall_start", 5);
        wait_drain("tlp2_drain", 200);
        stall = 1'b0;
        trn_tdst_rdy_n = 1'b0;
        chk("stall_rd_pulses", 64'(rd_cnt - rd_start), 64'd16);
        push_tlp(64'h0000_0000_4000_0000, 16);
        fifo_count = 10'd16;
        wait_sof("page2_start", 5);
        wait_drain("page2_drain", 100);
        // Reset after five accepted data beats of the page-2 offset 0x80 TLP
        push_tlp(64'h0000_0000_4000_0080, 5);
        fifo_count = 10'd16;
        wait_sof("abort_start", 5);
        wait_drain("abort_drain", 100);
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("mid_reset");
        step();
        reset_n = 1'b1;
        push_tlp(64'h0000_0001_FFFF_FF80, 16);
        fifo_count = 10'd16;
        wait_sof("post_reset_start", 5);
        wait_drain("post_reset_drain", 100);
        // One word short of a payload stays idle; a full payload starts
        push_tlp(64'h0000_0002_0000_0000, 16);
        push_free(2'b01);
        fifo_count = 10'd15;
        repeat (8) step();
        chk("short_fifo_idle", 64'(trn_tsrc_rdy_n), 64'd1);
        fifo_count = 10'd16;
        wait_sof("full_fifo_start", 3);
        wait_drain("final_drain", 100);
        repeat (3) step();
        @(negedge trn_clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
